// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential multiplier: FSM encoding and ALU opcodes.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_ROR = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

endpackage

// File: rtl/mult_seq_alu.sv
// General-purpose combinational ALU.
// Ofl is the unsigned carry-out for ADD when sign=0, and the two's-complement overflow when sign=1.
module alu
    import mult_seq_pkg::*;
#(
    parameter int OPERAND_WIDTH = 16
) (
    input  logic [2:0]               Oper,
    input  logic [OPERAND_WIDTH-1:0] InA,
    input  logic [OPERAND_WIDTH-1:0] InB,
    input  logic                     Cin,
    input  logic                     invA,
    input  logic                     invB,
    input  logic                     sign,
    output logic [OPERAND_WIDTH-1:0] Out,
    output logic                     Ofl
);

    localparam int W = OPERAND_WIDTH;

    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   sum;
    logic         sgn_ovf;

    assign a       = invA ? ~InA : InA;
    assign b       = invB ? ~InB : InB;
    assign sum     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, Cin};
    assign sgn_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);

    always_comb begin
        Out = '0;
        Ofl = 1'b0;
        case (Oper)
            OP_ROL: Out = {a[W-2:0], a[W-1]};
            OP_SLL: Out = {a[W-2:0], 1'b0};
            OP_ROR: Out = {a[0], a[W-1:1]};
            OP_SRL: Out = {1'b0, a[W-1:1]};
            OP_ADD: begin
                Out = sum[W-1:0];
                Ofl = sign ? sgn_ovf : sum[W];
            end
            OP_AND: Out = a & b;
            OP_OR:  Out = a | b;
            OP_XOR: Out = a ^ b;
            default: begin
                Out = '0;
                Ofl = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mult_seq.sv
// Unsigned shift-and-add multiplier: one ALU add and one right shift per CALC cycle.
// start is a request sampled only in IDLE; done is a one-cycle pulse and Product holds until the next accepted start.
module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   InA,
    input  logic [WIDTH-1:0]   InB,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Product,
    output logic               Zero,
    output state_t             state_dbg
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   mcand;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   alu_b;
    logic [WIDTH-1:0]   alu_out;
    logic               alu_ofl;
    logic [2*WIDTH-1:0] shifted;
    logic               last_calc;

    assign alu_b     = acc_lo[0] ? mcand : '0;
    // The carry becomes the new MSB so the partial sum never loses a bit.
    assign shifted   = {alu_ofl, alu_out, acc_lo[WIDTH-1:1]};
    assign last_calc = (count == CNT_W'(WIDTH - 1));

    alu #(
        .OPERAND_WIDTH(WIDTH)
    ) u_alu (
        .Oper (OP_ADD),
        .InA  (acc_hi),
        .InB  (alu_b),
        .Cin  (1'b0),
        .invA (1'b0),
        .invB (1'b0),
        .sign (1'b0),
        .Out  (alu_out),
        .Ofl  (alu_ofl)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_calc) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_hi  <= '0;
            acc_lo  <= '0;
            mcand   <= '0;
            count   <= '0;
            Product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_hi <= '0;
                        acc_lo <= InB;
                        mcand  <= InA;
                        count  <= '0;
                    end
                end
                CALC: begin
                    {acc_hi, acc_lo} <= shifted;
                    count            <= count + CNT_W'(1);
                    if (last_calc) Product <= shifted;
                end
                default: ;
            endcase
        end
    end

    assign Zero      = (Product == '0);
    assign state_dbg = state;

endmodule

// File: tb/tb_mult_seq.sv
// Directed self-checking bench for mult_seq (WIDTH=16).
module tb_mult_seq;
    import mult_seq_pkg::*;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic           zero;
    state_t         state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    mult_seq #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .InA       (in_a),
        .InB       (in_b),
        .busy      (busy),
        .done      (done),
        .Product   (product),
        .Zero      (zero),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples at negedges starting with the current one.
    task automatic wait_done(input int limit, output int busy_cycles, output bit seen);
        seen        = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < limit; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp);
        int bc;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        in_a  = a;
        in_b  = b;
        @(negedge clk);
        start = 1'b0;
        in_a  = W'($urandom);
        in_b  = W'($urandom);
        wait_done(40, bc, seen);
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_busy_cycles"}, 64'(bc), 64'd16);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_product"}, 64'(product), 64'(exp));
        check({tag, "_zero"}, 64'(zero), 64'(exp == '0));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check({tag, "_back_idle"}, 64'(state_dbg), 64'(IDLE));
    endtask

    initial begin
        int  bc;
        bit  seen;
        int  done_count;
        int  busy_after;
        logic [2*W-1:0] cap;
        int  last_done;
        logic [W-1:0]   b2b_a [3];
        logic [W-1:0]   b2b_b [3];
        logic [2*W-1:0] b2b_p [3];

        b2b_a = '{16'h00FF, 16'hABCD, 16'h1234};
        b2b_b = '{16'h0101, 16'h0002, 16'h5678};
        b2b_p = '{32'h0000FFFF, 32'h0001579A, 32'h06260060};

        rst   = 1'b1;
        start = 1'b0;
        in_a  = '0;
        in_b  = '0;
        repeat (2) @(negedge clk);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        check("rst_zero", 64'(zero), 64'd1);
        rst = 1'b0;

        run_op("basic_3x5", 16'd3, 16'd5, 32'h0000000F);

        repeat (3) @(negedge clk);
        check("idle_hold_product", 64'(product), 64'h0F);
        check("idle_hold_zero", 64'(zero), 64'd0);
        check("idle_hold_state", 64'(state_dbg), 64'(IDLE));

        run_op("carry_ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        run_op("zero_operand", 16'h1234, 16'h0000, 32'h00000000);
        run_op("ffff_x1", 16'hFFFF, 16'h0001, 32'h0000FFFF);

        // start while busy: second request at CALC cycle 5 must be ignored
        @(negedge clk);
        start = 1'b1;
        in_a  = 16'd7;
        in_b  = 16'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        in_a  = 16'd2;
        in_b  = 16'd2;
        @(negedge clk);
        start      = 1'b0;
        done_count = 0;
        busy_after = 0;
        cap        = '0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                done_count++;
                cap = product;
            end else if (done_count > 0 && busy) begin
                busy_after++;
            end
            @(negedge clk);
        end
        check("busy_start_done_count", 64'(done_count), 64'd1);
        check("busy_start_product", 64'(cap), 64'd63);
        check("busy_start_no_second_op", 64'(busy_after), 64'd0);
        check("busy_start_idle", 64'(state_dbg), 64'(IDLE));

        // reset at CALC cycle 8
        start = 1'b1;
        in_a  = 16'd3;
        in_b  = 16'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_product", 64'(product), 64'd0);
        check("mid_rst_zero", 64'(zero), 64'd1);
        check("mid_rst_state", 64'(state_dbg), 64'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        wait_done(25, bc, seen);
        check("mid_rst_no_done", 64'(seen), 64'd0);
        check("mid_rst_no_busy", 64'(bc), 64'd0);
        run_op("after_rst_8000x2", 16'h8000, 16'h0002, 32'h00010000);

        // back-to-back with start held high
        @(negedge clk);
        start     = 1'b1;
        in_a      = b2b_a[0];
        in_b      = b2b_b[0];
        last_done = 0;
        for (int i = 0; i < 3; i++) begin
            wait_done(40, bc, seen);
            check($sformatf("b2b%0d_done_seen", i), 64'(seen), 64'd1);
            check($sformatf("b2b%0d_product", i), 64'(product), 64'(b2b_p[i]));
            if (i > 0) check($sformatf("b2b%0d_period", i), 64'(cyc - last_done), 64'd18);
            last_done = cyc;
            if (i < 2) begin
                in_a = b2b_a[i + 1];
                in_b = b2b_b[i + 1];
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("b2b_end_idle", 64'(state_dbg), 64'(IDLE));
        check("b2b_end_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
